// File: rtl/encryption_regfile_pkg.sv
// Shared constants for the encryption register file: register addresses,
// reset values of the key registers and the algorithm select encoding.
package encryption_regfile_pkg;

    // Register map (byte addresses on the register bus)
    localparam int unsigned ADDR_SELECT     = 'h00;
    localparam int unsigned ADDR_CAESAR     = 'h10;
    localparam int unsigned ADDR_SCYTALE    = 'h12;
    localparam int unsigned ADDR_ZIGZAG     = 'h14;
    localparam int unsigned ADDR_ACCESS_CNT = 'h30;
    localparam int unsigned ADDR_ERROR_CNT  = 'h32;

    // Key register reset values
    localparam logic [15:0] RST_SCYTALE = 16'hFFFF;
    localparam logic [15:0] RST_ZIGZAG  = 16'h0002;

    // Algorithm select encoding
    typedef enum logic [1:0] {
        SEL_CAESAR  = 2'd0,
        SEL_SCYTALE = 2'd1,
        SEL_ZIGZAG  = 2'd2
    } sel_e;

endpackage

// File: rtl/encryption_regfile_if.sv
// Register access bus between an initiator (master) and the register file
// (slave).
//   addr/read/write/wdata : request, valid for one cycle, driven by master
//   rdata/done/error      : response, one-cycle pulse, driven by slave
interface encryption_regfile_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned REG_WIDTH  = 16
) ();

    logic [ADDR_WIDTH-1:0] addr;
    logic                  read;
    logic                  write;
    logic [REG_WIDTH-1:0]  wdata;
    logic [REG_WIDTH-1:0]  rdata;
    logic                  done;
    logic                  error;

    modport master (
        output addr, read, write, wdata,
        input  rdata, done, error
    );

    modport slave (
        input  addr, read, write, wdata,
        output rdata, done, error
    );

endinterface

// File: rtl/encryption_regfile_counter.sv
// Housekeeping counter for the register file.
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   inc_i    : increment by one this cycle
//   clr_i    : clear to zero, wins over inc_i
//   count_o  : current count
// SATURATE=1 holds at all-ones, SATURATE=0 wraps to zero.
module regfile_counter #(
    parameter int unsigned WIDTH    = 16,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            if (SATURATE && (cnt_q == {WIDTH{1'b1}})) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/encryption_regfile.sv
// Memory-mapped configuration register file of the encryption datapath.
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : register access bus (slave side)
//   select      : algorithm select (0 caesar, 1 scytale, 2 zigzag)
//   caesar_key  : Caesar shift key
//   scytale_key : Scytale key {M, N}
//   zigzag_key  : ZigZag key
// Pipeline: a request sampled at edge N updates the key registers at N and is
// answered with a done pulse registered at edge N+1. The housekeeping counters
// update at N+1 as well, together with the done pulse.
module encryption_regfile
    import encryption_regfile_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned REG_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    encryption_regfile_if.slave  bus,
    output logic [1:0]           select,
    output logic [REG_WIDTH-1:0] caesar_key,
    output logic [REG_WIDTH-1:0] scytale_key,
    output logic [REG_WIDTH-1:0] zigzag_key
);

    // Configuration registers
    logic [1:0]           select_d, select_q;
    logic [REG_WIDTH-1:0] caesar_d, caesar_q;
    logic [REG_WIDTH-1:0] scytale_d, scytale_q;
    logic [REG_WIDTH-1:0] zigzag_d, zigzag_q;

    // First response stage: result of the access sampled at the last edge
    logic                 pend_d, pend_q;
    logic                 pend_err_d, pend_err_q;
    logic                 pend_clr_d, pend_clr_q;
    logic [REG_WIDTH-1:0] pend_rdata_d, pend_rdata_q;

    // Second response stage: what the bus sees
    logic                 done_d, done_q;
    logic                 error_d, error_q;
    logic [REG_WIDTH-1:0] rdata_d, rdata_q;

    logic [REG_WIDTH-1:0] access_cnt;
    logic [REG_WIDTH-1:0] error_cnt;

    // Address decode
    logic is_sel, is_caesar, is_scytale, is_zigzag, is_acc_cnt, is_err_cnt;
    logic mapped, req, acc_err, wr_ok;
    logic [REG_WIDTH-1:0] rd_val;

    always_comb begin
        is_sel     = (bus.addr == ADDR_WIDTH'(ADDR_SELECT));
        is_caesar  = (bus.addr == ADDR_WIDTH'(ADDR_CAESAR));
        is_scytale = (bus.addr == ADDR_WIDTH'(ADDR_SCYTALE));
        is_zigzag  = (bus.addr == ADDR_WIDTH'(ADDR_ZIGZAG));
        is_acc_cnt = (bus.addr == ADDR_WIDTH'(ADDR_ACCESS_CNT));
        is_err_cnt = (bus.addr == ADDR_WIDTH'(ADDR_ERROR_CNT));
        mapped     = is_sel | is_caesar | is_scytale | is_zigzag | is_acc_cnt | is_err_cnt;

        req     = bus.read | bus.write;
        // Simultaneous read+write, unmapped address and writes to the
        // read-only access counter all fail without touching any register.
        acc_err = req & ((bus.read & bus.write) | ~mapped | (bus.write & is_acc_cnt));
        wr_ok   = bus.write & ~bus.read & ~acc_err;

        rd_val = '0;
        if (is_sel)     rd_val = {{(REG_WIDTH - 2){1'b0}}, select_q};
        if (is_caesar)  rd_val = caesar_q;
        if (is_scytale) rd_val = scytale_q;
        if (is_zigzag)  rd_val = zigzag_q;
        if (is_acc_cnt) rd_val = access_cnt;
        if (is_err_cnt) rd_val = error_cnt;
    end

    // Register writes land on the sampling edge
    always_comb begin
        select_d  = select_q;
        caesar_d  = caesar_q;
        scytale_d = scytale_q;
        zigzag_d  = zigzag_q;
        if (wr_ok) begin
            if (is_sel)     select_d  = bus.wdata[1:0];
            if (is_caesar)  caesar_d  = bus.wdata;
            if (is_scytale) scytale_d = bus.wdata;
            if (is_zigzag)  zigzag_d  = bus.wdata;
        end
    end

    always_comb begin
        pend_d       = req;
        pend_err_d   = acc_err;
        // The error-counter clear is deferred so it meets the counter on the
        // same edge as a possible increment and can override it.
        pend_clr_d   = wr_ok & is_err_cnt;
        pend_rdata_d = (bus.read & ~acc_err) ? rd_val : '0;

        done_d  = pend_q;
        error_d = pend_q & pend_err_q;
        rdata_d = pend_q ? pend_rdata_q : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            select_q     <= SEL_CAESAR;
            caesar_q     <= '0;
            scytale_q    <= REG_WIDTH'(RST_SCYTALE);
            zigzag_q     <= REG_WIDTH'(RST_ZIGZAG);
            pend_q       <= 1'b0;
            pend_err_q   <= 1'b0;
            pend_clr_q   <= 1'b0;
            pend_rdata_q <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            rdata_q      <= '0;
        end else begin
            select_q     <= select_d;
            caesar_q     <= caesar_d;
            scytale_q    <= scytale_d;
            zigzag_q     <= zigzag_d;
            pend_q       <= pend_d;
            pend_err_q   <= pend_err_d;
            pend_clr_q   <= pend_clr_d;
            pend_rdata_q <= pend_rdata_d;
            done_q       <= done_d;
            error_q      <= error_d;
            rdata_q      <= rdata_d;
        end
    end

    regfile_counter #(
        .WIDTH    (REG_WIDTH),
        .SATURATE (1'b0)
    ) u_access_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (pend_q),
        .clr_i   (1'b0),
        .count_o (access_cnt)
    );

    regfile_counter #(
        .WIDTH    (REG_WIDTH),
        .SATURATE (1'b1)
    ) u_error_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (pend_q & pend_err_q),
        .clr_i   (pend_clr_q),
        .count_o (error_cnt)
    );

    assign bus.done    = done_q;
    assign bus.error   = error_q;
    assign bus.rdata   = rdata_q;
    assign select      = select_q;
    assign caesar_key  = caesar_q;
    assign scytale_key = scytale_q;
    assign zigzag_key  = zigzag_q;

endmodule

// File: tb/tb_encryption_regfile.sv
// Directed self-checking bench for encryption_regfile. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_encryption_regfile;

    logic        clk;
    logic        rst;
    logic [1:0]  select;
    logic [15:0] caesar_key;
    logic [15:0] scytale_key;
    logic [15:0] zigzag_key;

    int n_checks = 0;
    int n_errors = 0;

    encryption_regfile_if #(.ADDR_WIDTH(8), .REG_WIDTH(16)) bus ();

    encryption_regfile #(
        .ADDR_WIDTH (8),
        .REG_WIDTH  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .select      (select),
        .caesar_key  (caesar_key),
        .scytale_key (scytale_key),
        .zigzag_key  (zigzag_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_mapped(input logic [7:0] a);
        return (a == 8'h00) || (a == 8'h10) || (a == 8'h12) || (a == 8'h14) ||
               (a == 8'h30) || (a == 8'h32);
    endfunction

    // One isolated access; lat is the number of falling edges after the
    // sampling edge at which done was seen (1 expected), -1 if never.
    task automatic do_access(input logic rd, input logic wr, input logic [7:0] a,
                             input logic [15:0] wd, output logic [15:0] rdata_o,
                             output logic err_o, output int lat);
        @(negedge clk);
        bus.read  = rd;
        bus.write = wr;
        bus.addr  = a;
        bus.wdata = wd;
        @(negedge clk);
        bus.read  = 1'b0;
        bus.write = 1'b0;
        lat     = -1;
        rdata_o = 16'hDEAD;
        err_o   = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            if (lat < 0 && bus.done) begin
                lat     = i - 1;
                rdata_o = bus.rdata;
                err_o   = bus.error;
            end
            if (lat < 0) @(negedge clk);
        end
        if (lat < 0) $display("FAIL timeout: no done for addr 0x%0h", a);
    endtask

    logic [15:0] rv;
    logic        ev;
    int          lat;
    int          done_seen;

    initial begin
        bus.addr  = '0;
        bus.read  = 1'b0;
        bus.write = 1'b0;
        bus.wdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        check_eq("rst_select", 32'(select), 32'h0);
        check_eq("rst_caesar", 32'(caesar_key), 32'h0);
        check_eq("rst_scytale", 32'(scytale_key), 32'hFFFF);
        check_eq("rst_zigzag", 32'(zigzag_key), 32'h0002);
        check_eq("rst_done", 32'(bus.done), 32'h0);
        check_eq("rst_error", 32'(bus.error), 32'h0);
        check_eq("rst_rdata", 32'(bus.rdata), 32'h0);
        rst = 1'b0;

        // Reset values through the bus
        do_access(1, 0, 8'h00, 16'h0, rv, ev, lat);
        check_eq("rd_sel", 32'(rv), 32'h0000);
        check_eq("rd_sel_err", 32'(ev), 32'h0);
        check_eq("rd_sel_lat", 32'(lat), 32'h1);
        do_access(1, 0, 8'h10, 16'h0, rv, ev, lat);
        check_eq("rd_caesar", 32'(rv), 32'h0000);
        check_eq("rd_caesar_err", 32'(ev), 32'h0);
        check_eq("rd_caesar_lat", 32'(lat), 32'h1);
        do_access(1, 0, 8'h12, 16'h0, rv, ev, lat);
        check_eq("rd_scytale", 32'(rv), 32'hFFFF);
        check_eq("rd_scytale_err", 32'(ev), 32'h0);
        check_eq("rd_scytale_lat", 32'(lat), 32'h1);
        do_access(1, 0, 8'h14, 16'h0, rv, ev, lat);
        check_eq("rd_zigzag", 32'(rv), 32'h0002);
        check_eq("rd_zigzag_err", 32'(ev), 32'h0);
        check_eq("rd_zigzag_lat", 32'(lat), 32'h1);
        do_access(1, 0, 8'h30, 16'h0, rv, ev, lat);
        check_eq("rd_acc_cnt", 32'(rv), 32'h0004);

        // Select write keeps only the low two bits; visible right after the sampling edge
        @(negedge clk);
        bus.write = 1'b1;
        bus.addr  = 8'h00;
        bus.wdata = 16'hABCE;
        @(negedge clk);
        bus.write = 1'b0;
        check_eq("sel_on_edge", 32'(select), 32'h2);
        check_eq("sel_done_not_yet", 32'(bus.done), 32'h0);
        @(negedge clk);
        check_eq("sel_wr_done", 32'(bus.done), 32'h1);
        check_eq("sel_wr_err", 32'(bus.error), 32'h0);
        check_eq("sel_wr_rdata", 32'(bus.rdata), 32'h0);
        do_access(1, 0, 8'h00, 16'h0, rv, ev, lat);
        check_eq("rd_sel2", 32'(rv), 32'h0002);

        do_access(0, 1, 8'h12, 16'h0304, rv, ev, lat);
        check_eq("wr_scytale_err", 32'(ev), 32'h0);
        check_eq("scytale_out", 32'(scytale_key), 32'h0304);
        do_access(1, 0, 8'h12, 16'h0, rv, ev, lat);
        check_eq("rd_scytale2", 32'(rv), 32'h0304);

        // Address sweep, starting from a cleared error counter
        do_access(0, 1, 8'h32, 16'h0, rv, ev, lat);
        check_eq("errcnt_clr_err", 32'(ev), 32'h0);
        for (int a = 0; a < 256; a++) begin
            do_access(1, 0, 8'(a), 16'h0, rv, ev, lat);
            check_eq($sformatf("sweep_rd_err_%02h", a), 32'(ev), 32'(!is_mapped(8'(a))));
        end
        for (int a = 0; a < 256; a++) begin
            if (a != 'h32) begin
                do_access(0, 1, 8'(a), 16'(16'h100 + a), rv, ev, lat);
                check_eq($sformatf("sweep_wr_err_%02h", a), 32'(ev),
                         32'(!is_mapped(8'(a)) || a == 'h30));
            end
        end
        check_eq("sweep_select", 32'(select), 32'h0);
        check_eq("sweep_caesar", 32'(caesar_key), 32'h0110);
        check_eq("sweep_scytale", 32'(scytale_key), 32'h0112);
        check_eq("sweep_zigzag", 32'(zigzag_key), 32'h0114);
        do_access(1, 0, 8'h32, 16'h0, rv, ev, lat);
        check_eq("sweep_errcnt", 32'(rv), 32'd501);

        // Simultaneous read and write
        do_access(1, 1, 8'h10, 16'h0055, rv, ev, lat);
        check_eq("rw_both_err", 32'(ev), 32'h1);
        check_eq("rw_both_rdata", 32'(rv), 32'h0);
        check_eq("rw_both_caesar", 32'(caesar_key), 32'h0110);
        do_access(0, 1, 8'h32, 16'h1234, rv, ev, lat);
        check_eq("errcnt_clr2_err", 32'(ev), 32'h0);
        do_access(1, 0, 8'h32, 16'h0, rv, ev, lat);
        check_eq("errcnt_after_clr", 32'(rv), 32'h0);

        // Back-to-back requests
        @(negedge clk);
        bus.write = 1'b1; bus.read = 1'b0; bus.addr = 8'h10; bus.wdata = 16'h0007;
        @(negedge clk);
        bus.write = 1'b0; bus.read = 1'b1; bus.addr = 8'h10;
        check_eq("b2b_idle", 32'(bus.done), 32'h0);
        @(negedge clk);
        bus.addr = 8'h99;
        check_eq("b2b_done0", 32'(bus.done), 32'h1);
        check_eq("b2b_rdata0", 32'(bus.rdata), 32'h0);
        check_eq("b2b_err0", 32'(bus.error), 32'h0);
        @(negedge clk);
        bus.read = 1'b0;
        check_eq("b2b_done1", 32'(bus.done), 32'h1);
        check_eq("b2b_rdata1", 32'(bus.rdata), 32'h0007);
        check_eq("b2b_err1", 32'(bus.error), 32'h0);
        @(negedge clk);
        check_eq("b2b_done2", 32'(bus.done), 32'h1);
        check_eq("b2b_rdata2", 32'(bus.rdata), 32'h0);
        check_eq("b2b_err2", 32'(bus.error), 32'h1);
        @(negedge clk);
        check_eq("b2b_after", 32'(bus.done), 32'h0);

        // Reset during a pending write
        bus.write = 1'b1; bus.addr = 8'h14; bus.wdata = 16'h5555;
        @(negedge clk);
        bus.write = 1'b0;
        check_eq("mid_rst_zz_written", 32'(zigzag_key), 32'h5555);
        rst = 1'b1;
        done_seen = 0;
        @(negedge clk);
        if (bus.done) done_seen++;
        check_eq("mid_rst_zigzag", 32'(zigzag_key), 32'h0002);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check_eq("mid_rst_no_done", 32'(done_seen), 32'h0);
        do_access(1, 0, 8'h30, 16'h0, rv, ev, lat);
        check_eq("mid_rst_acc_cnt", 32'(rv), 32'h0);
        check_eq("mid_rst_acc_err", 32'(ev), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/encryption_regfile.md
Name: encryption_regfile

Overview:
Memory-mapped register file that answers the addr/read/write/wdata handshake issued by the cipher tester or bus master. It holds the configuration of the encryption datapath: algorithm select plus Caesar, Scytale and ZigZag keys, exported as static outputs. It also keeps two read-only housekeeping counters. It is the responder end of the same register-access protocol the test bench drives as initiator.

Parameters:
ADDR_WIDTH, 8, register address width
REG_WIDTH, 16, register / data width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
addr  in  ADDR_WIDTH  register address, sampled with read/write
read  in  1  read request, single-cycle pulse
write  in  1  write request, single-cycle pulse
wdata  in  REG_WIDTH  write data, sampled with write
rdata  out  REG_WIDTH  read data, valid while done=1
done  out  1  access completion, one-cycle pulse
error  out  1  access failed, valid while done=1
select  out  2  algorithm select (0 caesar, 1 scytale, 2 zigzag)
caesar_key  out  REG_WIDTH  Caesar shift key
scytale_key  out  REG_WIDTH  Scytale key, {M[15:8], N[7:0]}
zigzag_key  out  REG_WIDTH  ZigZag key

Behaviour:
- Reset (async, rst=1): select=0, caesar_key=0, scytale_key=16'hFFFF, zigzag_key=16'h0002, ACCESS_CNT=0, ERROR_CNT=0, rdata=0, done=0, error=0.
- Register map:
  - 0x00 SELECT: RW; writes store wdata[1:0], upper bits ignored; reads return {14'b0, select}.
  - 0x10 CAESAR_KEY: RW.
  - 0x12 SCYTALE_KEY: RW.
  - 0x14 ZIGZAG_KEY: RW.
  - 0x30 ACCESS_CNT: RO. Counts every completed access, including errored ones. Wraps 0xFFFF->0. A write to it is an error.
  - 0x32 ERROR_CNT: RO. Counts errored accesses and saturates at 0xFFFF. A write of any value clears it to 0; that write is not an error.
- Any other address, read or write -> error.
- Latency: a request sampled at edge N gives done=1 for exactly the cycle after edge N+1, with error and rdata valid in that same cycle.
- Key and select outputs update at edge N, the same edge the write is sampled.
- Back-to-back requests every cycle are accepted; each one gets its own done pulse one cycle later.
- read and write both high in the same cycle -> error; no state changes except the counters.
- Error response: done=1, error=1, rdata=0, no register modified.
- Successful write: done=1, error=0, rdata=0.
- Successful read: rdata = register value as it was before any same-edge update.
- The counters update on the same edge that done is registered.
- A same-edge ERROR_CNT clear-write takes priority over an increment. The clear-write itself counts in ACCESS_CNT.
- Reset asserted mid-access: the pending done is dropped and all registers return to reset values. No done pulse is issued after reset releases.
- read=write=0: done=0, error=0, rdata=0, and the outputs hold.

Decomposition:
- Package encryption_regfile_pkg holds:
  - address constants ADDR_SELECT, ADDR_CAESAR, ADDR_SCYTALE, ADDR_ZIGZAG, ADDR_ACCESS_CNT, ADDR_ERROR_CNT;
  - reset constants RST_SCYTALE=16'hFFFF and RST_ZIGZAG=16'h0002;
  - the select encoding (SEL_CAESAR=0, SEL_SCYTALE=1, SEL_ZIGZAG=2).
- One sub-module, regfile_counter: REG_WIDTH counter with inc, clr and a SATURATE parameter. It is instantiated twice, wrapping for ACCESS_CNT and saturating for ERROR_CNT.

Test Plan:
- Reset, then read 0x00/0x10/0x12/0x14 -> rdata 0x0000, 0x0000, 0xFFFF, 0x0002; error=0 each; done one cycle after each request; then read 0x30 -> 0x0004.
- Write 0x00=0xABCE -> select=2 on the sampling edge; read 0x00 -> 0x0002. Write 0x12=0x0304 -> scytale_key=0x0304; read back 0x0304.
- Sweep all 256 addresses with reads then writes (value 0x100+addr) -> error=1 exactly on the 250 unmapped addresses and on a write to 0x30. Keys stay unchanged by errored writes. ERROR_CNT reads 2*250+1=501.
- read=write=1 at 0x10 with wdata=0x55 -> error=1, caesar_key unchanged; a following write 0x32=0x1234 -> error=0; ERROR_CNT reads 0.
- Issue requests on 3 consecutive cycles (write 0x10=7, read 0x10, read 0x99) -> three done pulses on consecutive cycles, rdata 0, 7, 0; errors 0, 0, 1.
- Assert rst in the cycle after a write request to 0x14 -> no done pulse; zigzag_key=0x0002; ACCESS_CNT=0.
